// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared types and constants for the LED brightness fader.
// Provides default parameter values, the per-channel state encoding and a
// helper that derives the full-scale duty value from the PWM width.
package led_fader_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_PWM_BITS = 8;
  localparam int unsigned DEF_STEP_DIV = 1024;

  // Per-channel ramp state, decoded from duty and target (no flops of its own)
  typedef enum logic [1:0] {
    CH_OFF     = 2'd0,
    CH_RISING  = 2'd1,
    CH_ON      = 2'd2,
    CH_FALLING = 2'd3
  } led_ch_state_e;

  // Full-scale duty (all ones) for a given PWM counter width
  function automatic int unsigned max_duty(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fader_ch.sv
// led_fader_ch: one LED channel of the fader.
// Ramps its duty one step per step_tick toward the target (0 or full scale),
// latches the duty into the active PWM compare value only at period end, and
// drives a registered PWM output.
// Ports:
//   clk, reset   - system clock, async active-high reset
//   tgt          - registered target bit (1 = fully on, 0 = fully off)
//   step_tick    - one-cycle strobe allowing a single duty step
//   pwm_cnt      - shared free-running PWM counter
//   period_end   - high in the cycle where pwm_cnt is at full scale
//   led          - registered PWM drive
//   differs      - combinational, high while duty has not reached target
module led_fader_ch
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEF_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tgt,
  input  logic                step_tick,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                period_end,
  output logic                led,
  output logic                differs
);

  localparam int unsigned            MAX       = max_duty(PWM_BITS);
  localparam logic [PWM_BITS-1:0]    DUTY_MAX  = PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0]    DUTY_ZERO = '0;

  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] duty_d;
  logic [PWM_BITS-1:0] act_duty;
  logic                led_d;
  led_ch_state_e       ch_state;

  // Since the target is always 0 or full scale, the state follows directly
  // from the target bit and whether duty sits at the matching end stop.
  always_comb begin
    ch_state = CH_OFF;
    if (tgt) begin
      ch_state = (duty == DUTY_MAX) ? CH_ON : CH_RISING;
    end else begin
      ch_state = (duty == DUTY_ZERO) ? CH_OFF : CH_FALLING;
    end
  end

  // Next duty: one step toward target per tick; end stops hold, so no wrap
  always_comb begin
    duty_d = duty;
    if (step_tick) begin
      case (ch_state)
        CH_RISING:  duty_d = duty + PWM_BITS'(1);
        CH_FALLING: duty_d = duty - PWM_BITS'(1);
        default:    duty_d = duty;
      endcase
    end
  end

  assign differs = (ch_state == CH_RISING) || (ch_state == CH_FALLING);

  // Full scale forces constant on, since pwm_cnt never exceeds MAX
  assign led_d = (act_duty == DUTY_MAX) | (pwm_cnt < act_duty);

  // Duty ramp register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty <= '0;
    end else begin
      duty <= duty_d;
    end
  end

  // Active compare value only changes on a period boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_duty <= '0;
    end else if (period_end) begin
      act_duty <= duty;
    end
  end

  // Output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led <= 1'b0;
    end else begin
      led <= led_d;
    end
  end

endmodule

// File: rtl/led_fader.sv
// led_fader: per-LED linear brightness ramp between the LED PIO and the pins.
// Each in_port bit selects fully on / fully off; every channel ramps its PWM
// duty toward that target one step every STEP_DIV cycles and emits
// glitch-free PWM.
// Optional feature macro: LED_FADER_STATUS_EN adds the registered busy port.
// Ports:
//   clk      - system clock (same as the PIO)
//   reset    - async active-high reset
//   in_port  - WIDTH target bits from the PIO out_port
//   led_out  - WIDTH registered PWM drives, active-high
//   busy     - (LED_FADER_STATUS_EN only) high while any duty differs from target
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned PWM_BITS = DEF_PWM_BITS,
  parameter int unsigned STEP_DIV = DEF_STEP_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] led_out
`ifdef LED_FADER_STATUS_EN
  ,
  output logic             busy
`endif
);

  // STEP_DIV of 1 would give a zero-width counter; keep one bit that stays 0
  localparam int unsigned         STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = PWM_BITS'(max_duty(PWM_BITS));

  logic [WIDTH-1:0]    tgt_q;
  logic [STEP_W-1:0]   step_cnt;
  logic                step_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                period_end;
  logic [WIDTH-1:0]    differs;

  assign step_tick  = (step_cnt == STEP_LAST);
  assign period_end = (pwm_cnt == PWM_MAX);

  // Target capture from the PIO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_q <= '0;
    end else begin
      tgt_q <= in_port;
    end
  end

  // Step-rate divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt <= '0;
    end else if (step_tick) begin
      step_cnt <= '0;
    end else begin
      step_cnt <= step_cnt + STEP_W'(1);
    end
  end

  // Free-running PWM counter, wraps naturally at full scale
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // One ramp/PWM channel per LED
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    led_fader_ch #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tgt        (tgt_q[i]),
      .step_tick  (step_tick),
      .pwm_cnt    (pwm_cnt),
      .period_end (period_end),
      .led        (led_out[i]),
      .differs    (differs[i])
    );
  end

`ifdef LED_FADER_STATUS_EN
  // Registered ramp-in-progress status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= |differs;
    end
  end
`else
  logic unused_differs;
  assign unused_differs = ^differs;
`endif

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed self-checking bench for led_fader with PWM_BITS=4
// (MAX=15) and STEP_DIV=4. Edge numbers below count rising clock edges after
// each reset release; ticks land on edges 4,8,..., act_duty loads on 16,32,...
// busy is checked only when LED_FADER_STATUS_EN is defined for the build.
module tb_led_fader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_port;
  logic [7:0] led_out;
`ifdef LED_FADER_STATUS_EN
  logic       busy;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int k        = 0;

  logic [3:0] duty_mon [8];

  led_fader #(
    .WIDTH    (8),
    .PWM_BITS (4),
    .STEP_DIV (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .led_out (led_out)
`ifdef LED_FADER_STATUS_EN
    ,
    .busy    (busy)
`endif
  );

  assign duty_mon[0] = dut.g_ch[0].u_ch.duty;
  assign duty_mon[1] = dut.g_ch[1].u_ch.duty;
  assign duty_mon[2] = dut.g_ch[2].u_ch.duty;
  assign duty_mon[3] = dut.g_ch[3].u_ch.duty;
  assign duty_mon[4] = dut.g_ch[4].u_ch.duty;
  assign duty_mon[5] = dut.g_ch[5].u_ch.duty;
  assign duty_mon[6] = dut.g_ch[6].u_ch.duty;
  assign duty_mon[7] = dut.g_ch[7].u_ch.duty;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic tick_to(input int target);
    while (k < target) tick();
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reset with in_port already at its new value; release just before edge 1
  task automatic do_reset(input logic [7:0] pin);
    reset   = 1'b1;
    in_port = pin;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    k     = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         hi;
    logic [15:0] wave;
    logic [7:0]  msk;

    // Reset with all targets on: outputs clear and duties hold 0 until tick
    reset   = 1'b1;
    in_port = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    check("rst_led", led_out, 8'h00);
`ifdef LED_FADER_STATUS_EN
    check("rst_busy", {7'b0, busy}, 8'h00);
`endif
    reset = 1'b0;
    k     = 0;
    tick_to(3);
    check("a_duty0_pre", {4'b0, duty_mon[0]}, 8'd0);
    check("a_duty7_pre", {4'b0, duty_mon[7]}, 8'd0);
    tick_to(4);
    check("a_duty0_tick1", {4'b0, duty_mon[0]}, 8'd1);
    check("a_duty7_tick1", {4'b0, duty_mon[7]}, 8'd1);
    check("a_led_idle", led_out, 8'h00);
`ifdef LED_FADER_STATUS_EN
    check("a_busy", {7'b0, busy}, 8'h01);
`endif

    // Full rise of channel 0, PWM shape sampled mid-rise
    do_reset(8'h01);
    tick_to(2);
`ifdef LED_FADER_STATUS_EN
    check("b_busy_start", {7'b0, busy}, 8'h01);
`endif
    tick_to(16);
    hi = 0;
    repeat (16) begin
      tick();
      hi += int'(led_out[0]);
    end
    check("b_pwm_d3_count", 8'(hi), 8'd3);
    // act_duty=7 over edges 33..48; ticks at 36,40,44,48 must not disturb it
    wave = 16'h007F;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("b_pwm_d7_wave", led_out, {7'b0, wave[i]});
    end
    tick_to(59);
    check("b_duty_14", {4'b0, duty_mon[0]}, 8'd14);
    tick_to(60);
    check("b_duty_15", {4'b0, duty_mon[0]}, 8'd15);
`ifdef LED_FADER_STATUS_EN
    check("b_busy_last", {7'b0, busy}, 8'h01);
`endif
    tick_to(61);
    check("b_duty_sat", {4'b0, duty_mon[0]}, 8'd15);
`ifdef LED_FADER_STATUS_EN
    check("b_busy_done", {7'b0, busy}, 8'h00);
`endif
    tick_to(64);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("b_led_full_on", led_out, 8'h01);
    end

    // Reversal at duty 7: steps down from 7 with no jump
    do_reset(8'h01);
    tick_to(28);
    check("c_duty_7", {4'b0, duty_mon[0]}, 8'd7);
    in_port = 8'h00;
    tick_to(31);
    check("c_hold_7", {4'b0, duty_mon[0]}, 8'd7);
    tick_to(32);
    check("c_duty_6", {4'b0, duty_mon[0]}, 8'd6);
    tick_to(56);
    check("c_duty_0", {4'b0, duty_mon[0]}, 8'd0);
`ifdef LED_FADER_STATUS_EN
    check("c_busy_last", {7'b0, busy}, 8'h01);
`endif
    tick_to(57);
`ifdef LED_FADER_STATUS_EN
    check("c_busy_done", {7'b0, busy}, 8'h00);
`endif
    check("c_duty_floor", {4'b0, duty_mon[0]}, 8'd0);
    tick_to(64);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("c_led_full_off", led_out, 8'h00);
    end

    // Independent channels: 0xA5 ramps up, then 0x5A crosses over
    do_reset(8'hA5);
    msk = 8'hA5;
    tick_to(20);
    for (int i = 0; i < 8; i++)
      check("d_a5_tick5", {4'b0, duty_mon[i]}, msk[i] ? 8'd5 : 8'd0);
    in_port = 8'h5A;
    tick_to(24);
    for (int i = 0; i < 8; i++)
      check("d_cross_4_1", {4'b0, duty_mon[i]}, msk[i] ? 8'd4 : 8'd1);
    tick_to(32);
    for (int i = 0; i < 8; i++)
      check("d_cross_2_3", {4'b0, duty_mon[i]}, msk[i] ? 8'd2 : 8'd3);
    tick_to(40);
    for (int i = 0; i < 8; i++)
      check("d_cross_0_5", {4'b0, duty_mon[i]}, msk[i] ? 8'd0 : 8'd5);

    // Reset mid-ramp: outputs clear without a clock edge, ramp restarts at 0
    do_reset(8'h01);
    tick_to(37);
    check("e_duty_9", {4'b0, duty_mon[0]}, 8'd9);
    check("e_led_on", led_out, 8'h01);
    #1;
    reset = 1'b1;
    #1;
    check("e_led_async", led_out, 8'h00);
    check("e_duty_async", {4'b0, duty_mon[0]}, 8'd0);
`ifdef LED_FADER_STATUS_EN
    check("e_busy_async", {7'b0, busy}, 8'h00);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    k     = 0;
    tick_to(3);
    check("e_restart_hold", {4'b0, duty_mon[0]}, 8'd0);
    tick_to(4);
    check("e_restart_step", {4'b0, duty_mon[0]}, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
